// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage mux, 32x32 GPR array with two combinational read
// ports, and a committed-write counter for debug/performance monitoring.
// Optional feature macro: GPR_BYPASS_EN -- when defined, the read ports forward the
// value being written back in the same cycle (internal write-through).
module wb_regfile #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [4:0]       gprDes_in,
    input  logic [31:0]      aluOut_in,
    input  logic [31:0]      memOut_in,
    input  logic             regW_in,
    input  logic             memToR_in,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] wr_count
);

    // Addresses at or beyond NREG do not exist; they read 0 and never commit.
    localparam logic [5:0] NregW = 6'(NREG);

    logic [31:0]      gpr_q [NREG];
    logic [31:0]      gpr_d [NREG];
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic [31:0]      rs_arr;
    logic [31:0]      rt_arr;

    // Write-back select and commit qualifier; commit is held off while in reset.
    always_comb begin
        wb_data = memToR_in ? memOut_in : aluOut_in;
        wb_we   = rst & wb_en & regW_in & (gprDes_in != 5'd0)
                  & ({1'b0, gprDes_in} < NregW);
    end

    // Next-state for the array: only the addressed register takes the new value.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        for (int i = 1; i < NREG; i++) begin
            if (wb_we && (gprDes_in == 5'(i))) begin
                gpr_d[i] = wb_data;
            end
        end
    end

    // Next-state for the committed-write counter; wraps naturally.
    always_comb begin
        wr_count_d = wr_count_q;
        if (wb_we) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Raw array lookups; $0 is never written so index 0 is skipped and reads 0.
    always_comb begin
        rs_arr = '0;
        rt_arr = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs_addr == 5'(i)) begin
                rs_arr = gpr_q[i];
            end
            if (rt_addr == 5'(i)) begin
                rt_arr = gpr_q[i];
            end
        end
    end

    // Read port outputs, optionally forwarding the in-flight write-back value.
    always_comb begin
`ifdef GPR_BYPASS_EN
        rs_data = (wb_we && (rs_addr == gprDes_in)) ? wb_data : rs_arr;
        rt_data = (wb_we && (rt_addr == gprDes_in)) ? wb_data : rt_arr;
`else
        rs_data = rs_arr;
        rt_data = rt_arr;
`endif
        wr_count = wr_count_q;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file for the five-stage pipeline. Consumes the MEM/WB bundle (destination, ALU result, memory data, register-write and memory-to-register controls), selects the write-back value, commits it to a 32×32-bit GPR array and serves the two ID-stage read ports. Also keeps a count of committed register writes for the debug and performance bench.

## Interface
Parameters:
- NREG, 32, number of GPRs; address width is fixed at 5 bits.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- wb_en  in  1  write-back enable; 0 during pipeline freeze, blocks commit and count.
- gprDes_in  in  5  destination register from MEM/WB.
- aluOut_in  in  32  ALU result from MEM/WB.
- memOut_in  in  32  load data from MEM/WB.
- regW_in  in  1  register-write control from MEM/WB.
- memToR_in  in  1  1 selects memOut_in, 0 selects aluOut_in.
- rs_addr  in  5  read port A address (ID stage).
- rt_addr  in  5  read port B address (ID stage).
- rs_data  out  32  read port A data.
- rt_data  out  32  read port B data.
- wb_data  out  32  currently selected write-back value (combinational, for forwarding unit).
- wb_we  out  1  commit qualifier: wb_en & regW_in & (gprDes_in != 0).
- wr_count  out  CNT_W  number of committed writes since reset.

## Operation
- Write-back selection: wb_data = memToR_in ? memOut_in : aluOut_in. This is pure mux, with no registering.
- Commit: at posedge clk, if wb_we = 1, GPR[gprDes_in] <= wb_data. Otherwise the array is unchanged.
- Register $0: reads always return 0. Writes to $0 are discarded and are not counted, even when regW_in = 1.
- Reads: rs_data and rt_data are combinational from the array, subject to the bypass rule in Configuration.
- Counter: at posedge clk, if wb_we = 1, wr_count <= wr_count + 1.
  - Wraps modulo 2^CNT_W with no saturation.
- Freeze: while wb_en = 0, nothing commits and the count does not change, even if MEM/WB holds a valid write. A held bundle re-commits on every cycle wb_en = 1; that is idempotent for the array but increments wr_count each time.
- Reset: rst low asynchronously clears all GPRs to 0 and wr_count to 0.
  - rs_data and rt_data therefore read 0 during reset.
  - wb_data and wb_we follow their inputs combinationally. wb_we is additionally forced to 0 while rst is low.
  - A write coincident with reset assertion is lost. The first commit can occur at the first posedge after rst deasserts.

## Timing
- Write latency: data written at posedge N is visible on read ports from just after posedge N. This is one cycle after the bundle is presented.
- Read latency: 0 cycles (combinational).
- Same-cycle read of the register being written: the result depends on GPR_BYPASS_EN.
- Simultaneous reads: rs_addr = rt_addr is legal, and both ports return the same value.
- No handshake. Upstream freeze is signalled solely by wb_en.

## Configuration
- GPR_BYPASS_EN defined: internal write-through.
  - If wb_we = 1 and rs_addr (or rt_addr) equals gprDes_in and is non-zero, that port returns wb_data in the same cycle.
  - This lets ID read a value written back in the same cycle without an external forward.
- GPR_BYPASS_EN undefined: read ports return array contents only. The old value is returned until the commit edge, and the hazard unit must cover the WB→ID distance.

## Test plan
- Reset: hold rst=0 with random inputs, then release. Required: rs_data=rt_data=0 for all addresses, wr_count=0, no write during reset.
- ALU write-back: regW=1, memToR=0, gprDes=8, aluOut=0x0000_1234, wb_en=1 for one cycle. Required: next cycle rs_addr=8 gives 0x0000_1234 and wr_count=1.
- Load write-back and $0 protection, in consecutive cycles:
  - memToR=1, memOut=0xDEAD_BEEF, gprDes=9. Required: GPR9=0xDEAD_BEEF.
  - gprDes=0, regW=1. Required: $0 still reads 0, wb_we=0, wr_count increments only for the first write.
- Freeze: bundle gprDes=10, aluOut=5 with wb_en=0 for 3 cycles, then wb_en=1 for 2 cycles. Required: GPR10 unchanged during freeze, then =5, and wr_count +2.
- Same-cycle read, gprDes=rs_addr=rt_addr=11, aluOut=0xA5A5_A5A5, old GPR11=0. Required:
  - With GPR_BYPASS_EN: both ports return 0xA5A5_A5A5 before the edge.
  - Without GPR_BYPASS_EN: both ports return 0 before the edge and 0xA5A5_A5A5 after it.
- Counter wrap: build with CNT_W=4 and perform 17 committed writes. Required: wr_count=1.
